// File: rtl/synchronizer_core_pkg.sv
// Shared helpers for the multi-bit flop synchronizer.
package synchronizer_core_pkg;

    function automatic bit params_ok(input int len, input int stages);
        return (len >= 1) && (stages >= 2);
    endfunction

endpackage

// File: rtl/synchronizer_core.sv
// Per-bit STAGES-deep flop synchronizer into clk, with registered-edge rise/fall pulses.
module synchronizer_core
    import synchronizer_core_pkg::*;
#(
    parameter int LEN    = 1,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           en,
    input  logic [LEN-1:0] dataIn,
    output logic [LEN-1:0] dataOut,
    output logic [LEN-1:0] rise,
    output logic [LEN-1:0] fall
);

    generate
        if (!params_ok(LEN, STAGES)) begin : g_bad_params
            $error("synchronizer_core: need LEN >= 1 and STAGES >= 2");
        end
    endgenerate

    // Chain flops must stay adjacent and untouched so metastability can resolve.
    (* async_reg = "true", keep = "true", dont_touch = "true" *)
    logic [LEN-1:0] sync_q [STAGES];
    logic [LEN-1:0] prev;

    generate
        for (genvar s = 0; s < STAGES; s++) begin : g_stage
            if (s == 0) begin : g_first
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn)
                        sync_q[0] <= '0;
                    else if (en)
                        sync_q[0] <= dataIn;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn)
                        sync_q[s] <= '0;
                    else if (en)
                        sync_q[s] <= sync_q[s-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            prev <= '0;
        else if (en)
            prev <= sync_q[STAGES-1];
    end

    assign dataOut = sync_q[STAGES-1];
    // Gating by en lets an edge held across a disabled span report on the first enabled cycle.
    assign rise    = {LEN{en}} &  dataOut & ~prev;
    assign fall    = {LEN{en}} & ~dataOut &  prev;

endmodule

// File: tb/tb_synchronizer_core.sv
// Directed table plus hand sequences for the 2-bit/2-stage and 1-bit/4-stage synchronizer.
module tb_synchronizer_core;

    logic       clk = 1'b0;
    logic       resetn;
    logic       en;
    logic [1:0] din;
    logic [1:0] dout, rise, fall;
    logic       din2, dout2, rise2, fall2;

    int checks = 0;
    int errors = 0;

    synchronizer_core #(.LEN(2), .STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .en(en),
        .dataIn(din), .dataOut(dout), .rise(rise), .fall(fall)
    );

    synchronizer_core #(.LEN(1), .STAGES(4)) dut_deep (
        .clk(clk), .resetn(resetn), .en(en),
        .dataIn(din2), .dataOut(dout2), .rise(rise2), .fall(fall2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [1:0] din;
        logic [1:0] out;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [1:0] o, input logic [1:0] r, input logic [1:0] f);
        chk({name, ".dataOut"}, dout, o);
        chk({name, ".rise"}, rise, r);
        chk({name, ".fall"}, fall, f);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en, din, expected dataOut, rise, fall after the next rising edge
        vecs[0]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{1'b1, 2'b10, 2'b10, 2'b10, 2'b00};
        vecs[4]  = '{1'b1, 2'b10, 2'b10, 2'b00, 2'b00};
        vecs[5]  = '{1'b1, 2'b00, 2'b10, 2'b00, 2'b00};
        vecs[6]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b10};
        vecs[7]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[8]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[9]  = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[10] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[11] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[12] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[13] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[14] = '{1'b1, 2'b11, 2'b11, 2'b11, 2'b00};
        vecs[15] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00};
        vecs[16] = '{1'b1, 2'b01, 2'b11, 2'b00, 2'b00};
        vecs[17] = '{1'b1, 2'b01, 2'b01, 2'b00, 2'b10};
        vecs[18] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
        vecs[19] = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00};

        resetn = 1'b0;
        en     = 1'b1;
        din    = 2'b00;
        din2   = 1'b0;
        #3;
        chk3("reset", 2'b00, 2'b00, 2'b00);
        chk("reset.deep_out", {1'b0, dout2}, 2'b00);
        resetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            en  = vecs[i].en;
            din = vecs[i].din;
            step();
            chk3($sformatf("vec%0d", i), vecs[i].out, vecs[i].rise, vecs[i].fall);
        end

        // fall edge left pending while disabled must appear as soon as en returns
        en = 1'b1;
        #1;
        chk3("pending_fall", 2'b01, 2'b00, 2'b10);
        step();
        chk3("pending_done", 2'b01, 2'b00, 2'b00);

        // async reset from dataOut=11
        din = 2'b11;
        step();
        step();
        chk3("pre_reset", 2'b11, 2'b10, 2'b00);
        step();
        chk3("pre_reset_idle", 2'b11, 2'b00, 2'b00);
        #2 resetn = 1'b0;
        #1;
        chk3("async_reset", 2'b00, 2'b00, 2'b00);
        #1 resetn = 1'b1;
        step();
        chk3("post_reset_e1", 2'b00, 2'b00, 2'b00);
        step();
        chk3("post_reset_e2", 2'b11, 2'b11, 2'b00);
        step();
        chk3("post_reset_e3", 2'b11, 2'b00, 2'b00);

        // reset while a 0 is in flight: nothing may be reported for it
        din = 2'b00;
        step();
        chk3("inflight", 2'b11, 2'b00, 2'b00);
        #2 resetn = 1'b0;
        #1;
        chk3("inflight_reset", 2'b00, 2'b00, 2'b00);
        #1 resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk3($sformatf("inflight_after%0d", i), 2'b00, 2'b00, 2'b00);
        end

        // deep chain: exactly 4 edges of latency, single rise
        din2 = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("deep_out_e%0d", i), {1'b0, dout2}, (i >= 4) ? 2'b01 : 2'b00);
            chk($sformatf("deep_rise_e%0d", i), {1'b0, rise2}, (i == 4) ? 2'b01 : 2'b00);
            chk($sformatf("deep_fall_e%0d", i), {1'b0, fall2}, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
